// File: rtl/rv32i_types.sv
// Shared RV32I encodings and payload types for the data-side memory port.
package rv32i_types;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        LF3_LB  = 3'd0,
        LF3_LH  = 3'd1,
        LF3_LW  = 3'd2,
        LF3_LBU = 3'd4,
        LF3_LHU = 3'd5
    } load_funct3_t;

    typedef enum logic [2:0] {
        SF3_SB = 3'd0,
        SF3_SH = 3'd1,
        SF3_SW = 3'd2
    } store_funct3_t;

    // Request fields kept for the whole transaction after accept.
    typedef struct packed {
        logic       write;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } mem_req_t;

endpackage

// File: rtl/mem_align.sv
// Lane alignment for RV32I loads/stores: byte enables, shifted store data,
// extended load data and the illegal-access flag.
module mem_align
    import rv32i_types::*;
(
    input  logic            i_write,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_byte_enable_c,
    output logic [XLEN-1:0] o_wdata_c,
    output logic [XLEN-1:0] o_rdata_c,
    output logic            o_illegal_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_rdata >> {i_addr_lo, 3'b000});
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_byte_enable_c = '0;
        o_wdata_c       = '0;
        o_rdata_c       = '0;
        o_illegal_c     = 1'b0;
        if (i_write) begin
            case (i_funct3)
                SF3_SB: begin
                    o_byte_enable_c = 4'b0001 << i_addr_lo;
                    o_wdata_c       = XLEN'(i_wdata[7:0]) << {i_addr_lo, 3'b000};
                end
                SF3_SH: begin
                    o_byte_enable_c = 4'b0011 << i_addr_lo;
                    o_wdata_c       = i_addr_lo[1] ? {i_wdata[15:0], 16'h0000}
                                                   : {16'h0000, i_wdata[15:0]};
                    o_illegal_c     = i_addr_lo[0];
                end
                SF3_SW: begin
                    o_byte_enable_c = 4'b1111;
                    o_wdata_c       = i_wdata;
                    o_illegal_c     = |i_addr_lo;
                end
                default: o_illegal_c = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                LF3_LB, LF3_LBU: begin
                    o_byte_enable_c = 4'b0001 << i_addr_lo;
                    o_rdata_c       = (i_funct3 == LF3_LB) ? {{24{w_byte[7]}}, w_byte}
                                                           : {24'h000000, w_byte};
                end
                LF3_LH, LF3_LHU: begin
                    o_byte_enable_c = 4'b0011 << i_addr_lo;
                    o_rdata_c       = (i_funct3 == LF3_LH) ? {{16{w_half[15]}}, w_half}
                                                           : {16'h0000, w_half};
                    o_illegal_c     = i_addr_lo[0];
                end
                LF3_LW: begin
                    o_byte_enable_c = 4'b1111;
                    o_rdata_c       = i_rdata;
                    o_illegal_c     = |i_addr_lo;
                end
                default: o_illegal_c = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-side memory port: accepts one load/store, runs the mem_read/mem_write/
// mem_resp handshake with timeout, and returns aligned load data or an error.
module mem_access_unit
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_err,
    output logic [XLEN-1:0] resp_rdata,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [3:0]      mem_byte_enable,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_resp
);

    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    mem_req_t        r_req;
    logic [CNT_W-1:0] r_cnt;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic            r_resp_err;
    logic [XLEN-1:0] r_resp_rdata;
    logic            r_mem_read;
    logic            r_mem_write;
    logic [XLEN-1:0] r_mem_address;
    logic [3:0]      r_mem_byte_enable;
    logic [XLEN-1:0] r_mem_wdata;

    mem_req_t        w_req;
    logic [3:0]      w_byte_enable;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_rdata;
    logic            w_illegal;

    // While idle the aligner decodes the incoming request; afterwards the latched one.
    assign w_req = (r_state == S_IDLE) ? mem_req_t'({req_write, req_funct3, req_addr[1:0]})
                                       : r_req;

    mem_align u_mem_align (
        .i_write         (w_req.write),
        .i_funct3        (w_req.funct3),
        .i_addr_lo       (w_req.addr_lo),
        .i_wdata         (req_wdata),
        .i_rdata         (mem_rdata),
        .o_byte_enable_c (w_byte_enable),
        .o_wdata_c       (w_wdata),
        .o_rdata_c       (w_rdata),
        .o_illegal_c     (w_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= S_IDLE;
            r_req             <= '0;
            r_cnt             <= '0;
            r_req_ready       <= 1'b1;
            r_resp_valid      <= 1'b0;
            r_resp_err        <= 1'b0;
            r_resp_rdata      <= '0;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            r_mem_address     <= '0;
            r_mem_byte_enable <= '0;
            r_mem_wdata       <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req       <= w_req;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state      <= S_ERR;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state           <= S_BUS;
                            r_mem_read        <= ~req_write;
                            r_mem_write       <= req_write;
                            r_mem_address     <= {req_addr[XLEN-1:2], 2'b00};
                            r_mem_byte_enable <= w_byte_enable;
                            r_mem_wdata       <= w_wdata;
                        end
                    end
                end
                S_BUS: begin
                    // A response in the final allowed cycle beats the timeout.
                    if (mem_resp || (TIMEOUT_EN && (r_cnt == CNT_LAST))) begin
                        r_state           <= mem_resp ? S_DONE : S_ERR;
                        r_resp_valid      <= 1'b1;
                        r_resp_err        <= ~mem_resp;
                        r_resp_rdata      <= (mem_resp && !r_req.write) ? w_rdata : '0;
                        r_mem_read        <= 1'b0;
                        r_mem_write       <= 1'b0;
                        r_mem_address     <= '0;
                        r_mem_byte_enable <= '0;
                        r_mem_wdata       <= '0;
                    end else if (TIMEOUT_EN) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = r_req_ready;
    assign resp_valid      = r_resp_valid;
    assign resp_err        = r_resp_err;
    assign resp_rdata      = r_resp_rdata;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_mem_address;
    assign mem_byte_enable = r_mem_byte_enable;
    assign mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level expectation model plus
// a per-cycle compare process and literal pins from hand-worked examples.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .resp_rdata      (resp_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    typedef struct packed {
        logic        ready;
        logic        rd;
        logic        wr;
        logic        rv;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        e;
    bit          chk_en;
    int unsigned n_vec;
    int unsigned n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t idle_exp();
        exp_t x;
        x       = '0;
        x.ready = 1'b1;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference rules written as plain arithmetic on byte offsets.
    task automatic model(input bit wr, input int f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         output bit ill, output logic [3:0] be,
                         output logic [31:0] sd, output logic [31:0] ld);
        int unsigned off;
        int unsigned b;
        int unsigned h;
        off = int'(a[1:0]);
        b   = (rd >> (8 * off)) & 32'hFF;
        h   = (rd >> (8 * off)) & 32'hFFFF;
        ill = 1'b0;
        be  = '0;
        sd  = '0;
        ld  = '0;
        if (wr) begin
            if (f3 == 0) begin
                be = 4'(1 << off);
                sd = (wd & 32'hFF) << (8 * off);
            end else if (f3 == 1) begin
                ill = (off % 2) != 0;
                be  = 4'(3 << off);
                sd  = (wd & 32'hFFFF) << (8 * off);
            end else if (f3 == 2) begin
                ill = off != 0;
                be  = 4'hF;
                sd  = wd;
            end else begin
                ill = 1'b1;
            end
        end else begin
            case (f3)
                0: begin be = 4'(1 << off); ld = (b >= 128) ? b + 32'hFFFF_FF00 : b; end
                4: begin be = 4'(1 << off); ld = b; end
                1: begin ill = (off % 2) != 0; be = 4'(3 << off);
                         ld = (h >= 32768) ? h + 32'hFFFF_0000 : h; end
                5: begin ill = (off % 2) != 0; be = 4'(3 << off); ld = h; end
                2: begin ill = off != 0; be = 4'hF; ld = rd; end
                default: ill = 1'b1;
            endcase
        end
    endtask

    // Single compare point: outputs sampled on the falling edge every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e.ready));
            chk("mem_read", 32'(mem_read), 32'(e.rd));
            chk("mem_write", 32'(mem_write), 32'(e.wr));
            chk("resp_valid", 32'(resp_valid), 32'(e.rv));
            chk("resp_err", 32'(resp_err), 32'(e.err));
            if (e.rd || e.wr) begin
                chk("mem_address", mem_address, e.addr);
                chk("mem_byte_enable", 32'(mem_byte_enable), 32'(e.be));
            end
            if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
            if (e.rv) chk("resp_rdata", resp_rdata, e.rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dly: BUS cycle index carrying mem_resp, or -1 for no response (timeout).
    task automatic txn(input bit wr, input int f3, input logic [31:0] a,
                       input logic [31:0] wd, input int dly, input logic [31:0] rd,
                       input bit lit, input logic [3:0] lbe,
                       input logic [31:0] lwd, input logic [31:0] lrd);
        bit          ill;
        logic [3:0]  be;
        logic [31:0] sd;
        logic [31:0] ld;
        int          n;
        model(wr, f3, a, wd, rd, ill, be, sd, ld);
        tick();
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = 3'(f3);
        req_addr   = a;
        req_wdata  = wd;
        e          = idle_exp();
        tick();
        if (ill) begin
            req_valid = 1'b0;
            e         = '0;
            e.rv      = 1'b1;
            e.err     = 1'b1;
            if (lit) chk("lit_err_rdata", resp_rdata, lrd);
            tick();
            e = idle_exp();
        end else begin
            n = (dly < 0) ? int'(TO) : dly + 1;
            for (int i = 0; i < n; i++) begin
                if (i > 0) tick();
                // Junk request while busy must be ignored.
                req_valid  = 1'b1;
                req_write  = 1'b1;
                req_funct3 = 3'd7;
                req_addr   = $urandom();
                mem_resp   = (i == dly);
                mem_rdata  = (i == dly) ? rd : $urandom();
                e          = '0;
                e.rd       = ~wr;
                e.wr       = wr;
                e.addr     = a & 32'hFFFF_FFFC;
                e.be       = be;
                e.wdata    = sd;
                if (i == 0 && lit) begin
                    chk("lit_be", 32'(mem_byte_enable), 32'(lbe));
                    if (wr) chk("lit_wdata", mem_wdata, lwd);
                end
            end
            tick();
            mem_resp  = 1'b0;
            req_valid = 1'b0;
            e         = '0;
            e.rv      = 1'b1;
            e.err     = (dly < 0);
            e.rdata   = (wr || dly < 0) ? 32'h0 : ld;
            if (lit && !wr && dly >= 0) chk("lit_rdata", resp_rdata, lrd);
            tick();
            e = idle_exp();
        end
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        chk_en     = 1'b0;
        e          = idle_exp();
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_rdata  = '0;
        mem_resp   = 1'b0;
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Loads (zero-wait and delayed) with literal results.
        txn(0, 2, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        txn(0, 0, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF7F, 1, 4'b1000, 32'h0, 32'hFFFF_FF80);
        txn(0, 4, 32'h0000_0103, 32'h0, 1, 32'h80FF_FF7F, 1, 4'b1000, 32'h0, 32'h0000_0080);
        txn(0, 1, 32'h0000_0102, 32'h0, 0, 32'h80FF_FF7F, 1, 4'b1100, 32'h0, 32'hFFFF_80FF);
        txn(0, 5, 32'h0000_0100, 32'h0, 2, 32'h80FF_FF7F, 1, 4'b0011, 32'h0, 32'h0000_FF7F);
        txn(0, 0, 32'h0000_0101, 32'h0, 0, 32'h1234_5678, 1, 4'b0010, 32'h0, 32'h0000_0056);
        txn(0, 1, 32'h0000_0600, 32'h0, 1, 32'h0000_8001, 0, 4'h0, 32'h0, 32'h0);

        // Stores.
        txn(1, 0, 32'h0000_0201, 32'h1234_5678, 0, 32'h0, 1, 4'b0010, 32'h0000_7800, 32'h0);
        txn(1, 1, 32'h0000_0202, 32'h1234_5678, 1, 32'h0, 1, 4'b1100, 32'h5678_0000, 32'h0);
        txn(1, 2, 32'h0000_0300, 32'hA5A5_5A5A, 2, 32'h0, 1, 4'b1111, 32'hA5A5_5A5A, 32'h0);
        txn(1, 0, 32'h0000_0303, 32'hCAFE_F00D, 0, 32'h0, 1, 4'b1000, 32'h0D00_0000, 32'h0);

        // Illegal: misaligned and bad funct3.
        txn(0, 2, 32'h0000_0101, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
        txn(1, 1, 32'h0000_0203, 32'h1234_5678, 0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
        txn(0, 3, 32'h0000_0100, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        txn(0, 7, 32'h0000_0100, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        txn(1, 4, 32'h0000_0100, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        txn(0, 5, 32'h0000_0101, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

        // Response in the last allowed cycle wins over timeout.
        txn(0, 2, 32'h0000_0700, 32'h0, int'(TO) - 1, 32'h0BAD_F00D, 1, 4'b1111, 32'h0, 32'h0BAD_F00D);

        // Timeout, then a stray response that must be ignored.
        txn(0, 2, 32'h0000_0400, 32'h0, -1, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        mem_resp  = 1'b1;
        mem_rdata = 32'h1111_2222;
        e         = idle_exp();
        tick();
        mem_resp = 1'b0;
        tick();

        // Async reset in the middle of a bus wait.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h0000_0500;
        tick();
        req_valid = 1'b0;
        e         = '0;
        e.rd      = 1'b1;
        e.addr    = 32'h0000_0500;
        e.be      = 4'hF;
        tick();
        e = idle_exp();
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        tick();
        rst       = 1'b1;
        mem_resp  = 1'b1;
        mem_rdata = 32'h3333_4444;
        tick();
        mem_resp = 1'b0;
        tick();
        tick();

        // Normal operation after reset.
        txn(0, 2, 32'h0000_0800, 32'h0, 0, 32'h5555_AAAA, 1, 4'b1111, 32'h0, 32'h5555_AAAA);
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
